// File: rtl/sobel_3x3_sink.sv
// Sobel 3x3 window consumer: gradient magnitude, binary edge and frame position tracking.
// The edge-pixel output is named edge_o because `edge` is a reserved word.
module sobel_3x3_sink #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned IMG_W      = 640,
  parameter int unsigned IMG_H      = 480
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  sof,
  input  logic                  win_valid,
  input  logic [DATA_WIDTH-1:0] a1,
  input  logic [DATA_WIDTH-1:0] a2,
  input  logic [DATA_WIDTH-1:0] a3,
  input  logic [DATA_WIDTH-1:0] a4,
  input  logic [DATA_WIDTH-1:0] a5,
  input  logic [DATA_WIDTH-1:0] a6,
  input  logic [DATA_WIDTH-1:0] a7,
  input  logic [DATA_WIDTH-1:0] a8,
  input  logic [DATA_WIDTH-1:0] a9,
  input  logic [DATA_WIDTH-1:0] thresh,
  output logic [DATA_WIDTH-1:0] mag,
  output logic                  edge_o,
  output logic                  dout_valid,
  output logic                  frame_done
);

  localparam int unsigned CW = (IMG_W > 1) ? $clog2(IMG_W) : 1;
  localparam int unsigned RW = (IMG_H > 1) ? $clog2(IMG_H) : 1;
  localparam int unsigned PW = DATA_WIDTH + 2;
  localparam int unsigned GW = DATA_WIDTH + 4;

  // a + 2b + c, never exceeds 4*(2^DATA_WIDTH-1)
  function automatic logic [PW-1:0] tap_sum(input logic [DATA_WIDTH-1:0] a,
                                            input logic [DATA_WIDTH-1:0] b,
                                            input logic [DATA_WIDTH-1:0] c);
    return PW'(a) + PW'({b, 1'b0}) + PW'(c);
  endfunction

  function automatic logic [PW-1:0] abs_diff(input logic [PW-1:0] p,
                                             input logic [PW-1:0] n);
    logic signed [GW-1:0] d;
    d = $signed(GW'(p)) - $signed(GW'(n));
    if (d < 0) d = -d;
    return d[PW-1:0];
  endfunction

  logic [CW-1:0] col_q, col_d, beat_col;
  logic [RW-1:0] row_q, row_d, beat_row;
  logic          beat_border, beat_last;

  // sof with a beat makes that beat position (0,0); sof alone just clears the counters.
  always_comb begin
    beat_col    = sof ? '0 : col_q;
    beat_row    = sof ? '0 : row_q;
    beat_border = (32'(beat_row) < 32'd2) || (32'(beat_col) < 32'd2);
    beat_last   = (32'(beat_col) == IMG_W - 1) && (32'(beat_row) == IMG_H - 1);
    col_d       = col_q;
    row_d       = row_q;
    if (win_valid) begin
      if (32'(beat_col) == IMG_W - 1) begin
        col_d = '0;
        row_d = (32'(beat_row) == IMG_H - 1) ? '0 : beat_row + 1'b1;
      end else begin
        col_d = beat_col + 1'b1;
        row_d = beat_row;
      end
    end else if (sof) begin
      col_d = '0;
      row_d = '0;
    end
  end

  logic                  v1_q, bd1_q, last1_q;
  logic [DATA_WIDTH-1:0] thr1_q;
  logic [PW-1:0]         gxp_q, gxn_q, gyp_q, gyn_q;

  logic                  v2_q, bd2_q, last2_q;
  logic [DATA_WIDTH-1:0] thr2_q;
  logic [PW-1:0]         agx_q, agy_q;

  logic [DATA_WIDTH-1:0] mag_q, mag_d;
  logic                  edge_q, edge_d, dv_q, fd_q;
  logic [PW:0]           sum_d;
  logic [DATA_WIDTH-1:0] sat_d;

  always_comb begin
    sum_d  = (PW+1)'(agx_q) + (PW+1)'(agy_q);
    sat_d  = (|sum_d[PW:DATA_WIDTH]) ? '1 : sum_d[DATA_WIDTH-1:0];
    mag_d  = bd2_q ? '0 : sat_d;
    edge_d = !bd2_q && (sat_d >= thr2_q);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      col_q   <= '0;
      row_q   <= '0;
      v1_q    <= 1'b0;
      bd1_q   <= 1'b0;
      last1_q <= 1'b0;
      thr1_q  <= '0;
      gxp_q   <= '0;
      gxn_q   <= '0;
      gyp_q   <= '0;
      gyn_q   <= '0;
      v2_q    <= 1'b0;
      bd2_q   <= 1'b0;
      last2_q <= 1'b0;
      thr2_q  <= '0;
      agx_q   <= '0;
      agy_q   <= '0;
      mag_q   <= '0;
      edge_q  <= 1'b0;
      dv_q    <= 1'b0;
      fd_q    <= 1'b0;
    end else begin
      col_q   <= col_d;
      row_q   <= row_d;
      // S1: partial sums and per-beat side information
      v1_q    <= win_valid;
      bd1_q   <= beat_border;
      last1_q <= beat_last;
      thr1_q  <= thresh;
      gxp_q   <= tap_sum(a3, a6, a9);
      gxn_q   <= tap_sum(a1, a4, a7);
      gyp_q   <= tap_sum(a7, a8, a9);
      gyn_q   <= tap_sum(a1, a2, a3);
      // S2: gradient magnitudes per axis
      v2_q    <= v1_q;
      bd2_q   <= bd1_q;
      last2_q <= last1_q;
      thr2_q  <= thr1_q;
      agx_q   <= abs_diff(gxp_q, gxn_q);
      agy_q   <= abs_diff(gyp_q, gyn_q);
      // S3: pixel outputs only move on a valid beat, so they hold across gaps
      dv_q    <= v2_q;
      fd_q    <= v2_q && last2_q;
      if (v2_q) begin
        mag_q  <= mag_d;
        edge_q <= edge_d;
      end
    end
  end

  assign mag        = mag_q;
  assign edge_o     = edge_q;
  assign dout_valid = dv_q;
  assign frame_done = fd_q;

endmodule

// File: tb/tb_sobel_3x3_sink.sv
// Scoreboard bench for sobel_3x3_sink on an 8x6 frame with a plain-arithmetic reference model.
module tb_sobel_3x3_sink;

  localparam int W  = 8;
  localparam int H  = 6;
  localparam int DW = 8;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       sof = 1'b0;
  logic       win_valid = 1'b0;
  logic [7:0] tap [1:9];
  logic [7:0] thresh = 8'd0;
  logic [7:0] mag;
  logic       edge_o, dout_valid, frame_done;

  sobel_3x3_sink #(.DATA_WIDTH(DW), .IMG_W(W), .IMG_H(H)) dut (
    .clk(clk), .rst(rst), .sof(sof), .win_valid(win_valid),
    .a1(tap[1]), .a2(tap[2]), .a3(tap[3]), .a4(tap[4]), .a5(tap[5]),
    .a6(tap[6]), .a7(tap[7]), .a8(tap[8]), .a9(tap[9]),
    .thresh(thresh), .mag(mag), .edge_o(edge_o),
    .dout_valid(dout_valid), .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0]  mag;
    logic        e;
    logic        fd;
    int unsigned issue;
  } exp_t;

  exp_t        sb[$];
  exp_t        got;
  int unsigned cyc = 0;
  int unsigned n_pass = 0;
  int unsigned n_total = 0;
  int unsigned fd_seen = 0;
  int unsigned fd0;
  int          mrow = 0;
  int          mcol = 0;
  logic [7:0]  last_mag = 8'd0;
  logic        last_e = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input int act, input int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
  endtask

  function automatic int iabs(input int x);
    return (x < 0) ? -x : x;
  endfunction

  function automatic exp_t model(input int r, input int c, input int th, input int unsigned issue);
    exp_t e;
    int   v [1:9];
    int   gx, gy, m;
    for (int i = 1; i <= 9; i++) v[i] = int'(tap[i]);
    gx = (v[3] + 2*v[6] + v[9]) - (v[1] + 2*v[4] + v[7]);
    gy = (v[7] + 2*v[8] + v[9]) - (v[1] + 2*v[2] + v[3]);
    m  = iabs(gx) + iabs(gy);
    if (m > 255) m = 255;
    if (r < 2 || c < 2) begin
      e.mag = 8'd0;
      e.e   = 1'b0;
    end else begin
      e.mag = 8'(m);
      e.e   = (m >= th);
    end
    e.fd    = (r == H-1) && (c == W-1);
    e.issue = issue;
    return e;
  endfunction

  always @(negedge clk) begin
    if (rst) begin
      check("dout_valid_in_reset", dout_valid, 0);
    end else if (dout_valid) begin
      if (frame_done) fd_seen++;
      if (sb.size() == 0) begin
        check("unexpected_dout_valid", dout_valid, 0);
      end else begin
        got = sb.pop_front();
        check("latency", int'(cyc - got.issue), 3);
        check("mag", mag, got.mag);
        check("edge", edge_o, got.e);
        check("frame_done", frame_done, got.fd);
        last_mag = got.mag;
        last_e   = got.e;
      end
    end else begin
      check("hold_mag", mag, last_mag);
      check("hold_edge", edge_o, last_e);
      check("frame_done_idle", frame_done, 0);
    end
  end

  task automatic drive(input logic v, input logic s, input logic [7:0] th);
    int r, c;
    win_valid = v;
    sof       = s;
    thresh    = th;
    if (v) begin
      r = s ? 0 : mrow;
      c = s ? 0 : mcol;
      sb.push_back(model(r, c, th, cyc));
      c++;
      if (c == W) begin
        c = 0;
        r++;
        if (r == H) r = 0;
      end
      mrow = r;
      mcol = c;
    end else if (s) begin
      mrow = 0;
      mcol = 0;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic taps_fill(input logic [7:0] v);
    for (int i = 1; i <= 9; i++) tap[i] = v;
  endtask

  task automatic taps_edge();
    taps_fill(8'd20);
    tap[1] = 8'd10; tap[4] = 8'd10; tap[7] = 8'd10;
  endtask

  task automatic taps_gx_sat();
    taps_fill(8'd255);
    tap[1] = 8'd0; tap[4] = 8'd0; tap[7] = 8'd0;
  endtask

  task automatic taps_gy_sat();
    taps_fill(8'd255);
    tap[1] = 8'd0; tap[2] = 8'd0; tap[3] = 8'd0;
  endtask

  task automatic taps_random();
    for (int i = 1; i <= 9; i++) begin
      if ($urandom_range(0, 3) == 0) tap[i] = ($urandom_range(0, 1) == 1) ? 8'd255 : 8'd0;
      else tap[i] = 8'($urandom_range(0, 255));
    end
  endtask

  // mode 0 uniform, 1/2 directed windows at fixed positions, 3 random
  task automatic run_beats(input int n, input int mode, input int gap_pct);
    int         k;
    logic [7:0] th;
    k = 0;
    while (k < n) begin
      if (gap_pct > 0 && $urandom_range(0, 99) < gap_pct) begin
        drive(1'b0, 1'b0, thresh);
      end else begin
        taps_random();
        th = 8'($urandom_range(0, 255));
        if (mode == 0) begin
          taps_fill(8'd50);
          th = 8'd1;
        end else if (mode == 1) begin
          if ((mrow == 3 && mcol == 4) || (mrow == 1 && mcol == 5) || (mrow == 4 && mcol == 0)) begin
            taps_edge();
            th = 8'd40;
          end
        end else if (mode == 2) begin
          if (mrow == 3 && mcol == 4) begin
            taps_edge();
            th = 8'd41;
          end else if (mrow == 3 && mcol == 5) begin
            taps_gx_sat();
          end else if (mrow == 3 && mcol == 6) begin
            taps_gy_sat();
            th = 8'd255;
          end
        end
        drive(1'b1, 1'b0, th);
        k++;
      end
    end
  endtask

  task automatic drain();
    int k;
    k = 0;
    while (sb.size() != 0 && k < 10) begin
      drive(1'b0, 1'b0, thresh);
      k++;
    end
    check("drain_empty", sb.size(), 0);
  endtask

  task automatic do_reset();
    rst       = 1'b1;
    win_valid = 1'b0;
    sof       = 1'b0;
    sb.delete();
    mrow     = 0;
    mcol     = 0;
    last_mag = 8'd0;
    last_e   = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, %0d expectations pending", sb.size());
    $fatal(1, "watchdog");
  end

  initial begin
    taps_fill(8'd0);
    #1 rst = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    check("reset_mag", mag, 0);
    check("reset_edge", edge_o, 0);
    check("reset_dout_valid", dout_valid, 0);
    check("reset_frame_done", frame_done, 0);

    fd0 = fd_seen;
    run_beats(48, 0, 0);
    drain();
    check("uniform_frame_done_count", int'(fd_seen - fd0), 1);

    fd0 = fd_seen;
    run_beats(48, 1, 0);
    drain();
    run_beats(48, 2, 0);
    drain();
    check("directed_frame_done_count", int'(fd_seen - fd0), 2);

    fd0 = fd_seen;
    run_beats(26, 3, 0);
    taps_random();
    drive(1'b1, 1'b0, 8'd30);
    drive(1'b0, 1'b0, 8'd30);
    drive(1'b1, 1'b0, 8'd30);
    taps_edge();
    drive(1'b1, 1'b1, 8'd1);
    run_beats(47, 3, 0);
    drain();
    check("sof_frame_done_count", int'(fd_seen - fd0), 1);

    run_beats(10, 3, 0);
    run_beats(2, 3, 0);
    do_reset();
    fd0 = fd_seen;
    run_beats(48, 3, 0);
    drain();
    check("post_reset_frame_done_count", int'(fd_seen - fd0), 1);

    fd0 = fd_seen;
    repeat (3) begin
      run_beats(48, 3, 30);
      drain();
    end
    run_beats(20, 3, 30);
    drive(1'b0, 1'b1, 8'd0);
    run_beats(48, 3, 30);
    drain();
    check("random_frame_done_count", int'(fd_seen - fd0), 4);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
